// File: rtl/arb_pkg.sv
// Shared definitions for the arbiter client slots.
// State encoding and common defaults.
package arb_pkg;

    localparam int NUM_CLIENTS = 4;
    localparam int DW_DEF      = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        REL  = 2'd3
    } state_t;

endpackage

// File: rtl/arb_requester_sync_fifo.sv
// Small synchronous FIFO with a combinational read port.
// Pointers wrap modulo DEPTH; DEPTH must be a power of two.
module sync_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DW-1:0]            din,
    output logic [DW-1:0]            dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/arb_requester.sv
// Requesting agent for one slot of the fixed-priority arbiter.
// Buffers producer words and streams bounded bursts per grant.
module arb_requester
    import arb_pkg::*;
#(
    parameter int DW        = DW_DEF,
    parameter int DEPTH     = 8,
    parameter int MAX_BURST = 4,
    parameter int TIMEOUT   = 64
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   wr_valid,
    input  logic [DW-1:0]          wr_data,
    output logic                   wr_ready,
    output logic                   req,
    input  logic                   gnt,
    output logic                   bus_valid,
    output logic [DW-1:0]          bus_data,
    output logic                   bus_last,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   busy,
    output logic                   starve_err
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int BW = $clog2(MAX_BURST) + 1;
    localparam int TW = $clog2(TIMEOUT);

    state_t        state_q, state_d;
    logic          req_q, req_d;
    logic          bus_valid_q, bus_valid_d;
    logic [DW-1:0] bus_data_q, bus_data_d;
    logic          bus_last_q, bus_last_d;
    logic          starve_q, starve_d;
    logic [TW-1:0] wait_q, wait_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [BW-1:0] burst_len_q, burst_len_d;

    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [DW-1:0] fifo_dout;
    logic [CW-1:0] count;

    sync_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .n_rst (n_rst),
        .push  (wr_valid),
        .pop   (pop),
        .din   (wr_data),
        .dout  (fifo_dout),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        req_d       = 1'b0;
        bus_valid_d = 1'b0;
        bus_data_d  = '0;
        bus_last_d  = 1'b0;
        starve_d    = starve_q;
        wait_d      = wait_q;
        beat_d      = beat_q;
        burst_len_d = burst_len_q;
        pop         = 1'b0;
        unique case (state_q)
            IDLE: begin
                wait_d = '0;
                if (count != '0) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                end
            end
            REQ: begin
                req_d = 1'b1;
                if (gnt) begin
                    if (count >= CW'(MAX_BURST))
                        burst_len_d = BW'(MAX_BURST);
                    else
                        burst_len_d = BW'(count);
                    beat_d  = '0;
                    wait_d  = '0;
                    state_d = XFER;
                end else begin
                    if (wait_q != TW'(TIMEOUT-1))
                        wait_d = wait_q + TW'(1);
                    if (wait_d == TW'(TIMEOUT-1))
                        starve_d = 1'b1;
                end
            end
            XFER: begin
                if (gnt && !fifo_empty) begin
                    pop         = 1'b1;
                    bus_valid_d = 1'b1;
                    bus_data_d  = fifo_dout;
                    beat_d      = beat_q + BW'(1);
                    if (beat_q == burst_len_q - BW'(1)) begin
                        bus_last_d = 1'b1;
                        state_d    = REL;
                    end else begin
                        req_d = 1'b1;
                    end
                end else begin
                    state_d = REL;
                end
            end
            REL: begin
                // req returns together with IDLE so the gap is one cycle
                state_d = IDLE;
                req_d   = (count != '0);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            req_q       <= 1'b0;
            bus_valid_q <= 1'b0;
            bus_data_q  <= '0;
            bus_last_q  <= 1'b0;
            starve_q    <= 1'b0;
            wait_q      <= '0;
            beat_q      <= '0;
            burst_len_q <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            bus_valid_q <= bus_valid_d;
            bus_data_q  <= bus_data_d;
            bus_last_q  <= bus_last_d;
            starve_q    <= starve_d;
            wait_q      <= wait_d;
            beat_q      <= beat_d;
            burst_len_q <= burst_len_d;
        end
    end

    assign wr_ready   = !fifo_full;
    assign req        = req_q;
    assign bus_valid  = bus_valid_q;
    assign bus_data   = bus_data_q;
    assign bus_last   = bus_last_q;
    assign fifo_count = count;
    assign busy       = (state_q != IDLE);
    assign starve_err = starve_q;

endmodule

// File: tb/tb_arb_requester.sv
// Directed bench for arb_requester.
// Grant model and bus monitor run on the falling edge.
module tb_arb_requester;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       req;
    logic       gnt;
    logic       bus_valid;
    logic [7:0] bus_data;
    logic       bus_last;
    logic [3:0] fifo_count;
    logic       busy;
    logic       starve_err;

    arb_requester #(
        .DW        (8),
        .DEPTH     (8),
        .MAX_BURST (4),
        .TIMEOUT   (64)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .req        (req),
        .gnt        (gnt),
        .bus_valid  (bus_valid),
        .bus_data   (bus_data),
        .bus_last   (bus_last),
        .fifo_count (fifo_count),
        .busy       (busy),
        .starve_err (starve_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    // 0: gnt low, 1: grant whenever req, 2: gnt forced high
    int   mode = 0;
    int   drop_at = 0;
    bit   drop_armed = 0;
    int   nwords = 0;
    bit   had_req = 0;
    int   gap = 0;
    logic [7:0] qd [$];
    logic       ql [$];
    int         gaps [$];

    initial gnt = 1'b0;

    always @(negedge clk) begin
        if (bus_valid === 1'b1) begin
            qd.push_back(bus_data);
            ql.push_back(bus_last);
            nwords++;
        end
        if (req === 1'b1) begin
            if (had_req && gap > 0) gaps.push_back(gap);
            had_req = 1;
            gap = 0;
        end else if (had_req) begin
            gap++;
        end
        if (drop_armed && nwords >= drop_at && req !== 1'b1)
            drop_armed = 0;
        case (mode)
            1: gnt = (req === 1'b1) &&
                     !(drop_armed && nwords >= drop_at);
            2: gnt = 1'b1;
            default: gnt = 1'b0;
        endcase
    end

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        cyc(1);
        wr_valid = 1'b0;
    endtask

    task automatic clr();
        qd.delete();
        ql.delete();
        gaps.delete();
        nwords  = 0;
        had_req = 0;
        gap     = 0;
    endtask

    logic [7:0] exp3 [9];
    int k;

    initial begin
        n_rst    = 1'b0;
        wr_valid = 1'b0;
        wr_data  = '0;
        cyc(2);
        chk("rst_req", req, 0);
        chk("rst_bv", bus_valid, 0);
        chk("rst_bl", bus_last, 0);
        chk("rst_bd", bus_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_starve", starve_err, 0);
        chk("rst_wrrdy", wr_ready, 1);
        chk("rst_cnt", fifo_count, 0);
        n_rst = 1'b1;
        cyc(1);

        // 1: three-word tenure
        clr();
        wr(8'hA1);
        wr(8'hA2);
        wr(8'hA3);
        mode = 1;
        cyc(12);
        chk("t1_n", qd.size(), 3);
        if (qd.size() == 3) begin
            chk("t1_d0", qd[0], 8'hA1);
            chk("t1_d1", qd[1], 8'hA2);
            chk("t1_d2", qd[2], 8'hA3);
            chk("t1_l0", ql[0], 0);
            chk("t1_l1", ql[1], 0);
            chk("t1_l2", ql[2], 1);
        end
        chk("t1_cnt", fifo_count, 0);
        chk("t1_busy", busy, 0);
        chk("t1_req", req, 0);

        // 2: eight words split in two bursts
        mode = 0;
        clr();
        for (int i = 0; i < 8; i++) wr(8'h10 + 8'(i));
        chk("t2_cnt", fifo_count, 8);
        mode = 1;
        cyc(25);
        chk("t2_n", qd.size(), 8);
        if (qd.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                chk($sformatf("t2_d%0d", i), qd[i], 8'h10 + 8'(i));
                chk($sformatf("t2_l%0d", i), ql[i],
                    32'((i == 3) || (i == 7)));
            end
        end
        chk("t2_ngap", gaps.size(), 1);
        if (gaps.size() == 1) chk("t2_gap", gaps[0], 1);

        // 3: full FIFO, dropped write, push with pop
        mode = 0;
        clr();
        for (int i = 0; i < 8; i++) wr(8'h30 + 8'(i));
        chk("t3_cnt8", fifo_count, 8);
        chk("t3_wrrdy", wr_ready, 0);
        wr(8'h99);
        chk("t3_cnt8b", fifo_count, 8);
        mode = 2;
        cyc(2);
        chk("t3_cnt7", fifo_count, 7);
        wr_valid = 1'b1;
        wr_data  = 8'h3A;
        cyc(1);
        wr_valid = 1'b0;
        mode = 0;
        chk("t3_cnt7b", fifo_count, 7);
        cyc(1);
        mode = 1;
        cyc(35);
        for (int i = 0; i < 8; i++) exp3[i] = 8'h30 + 8'(i);
        exp3[8] = 8'h3A;
        chk("t3_n", qd.size(), 9);
        if (qd.size() == 9) begin
            for (int i = 0; i < 9; i++)
                chk($sformatf("t3_d%0d", i), qd[i], exp3[i]);
            chk("t3_l1", ql[1], 0);
            chk("t3_l5", ql[5], 1);
            chk("t3_l8", ql[8], 1);
        end
        chk("t3_cnt0", fifo_count, 0);

        // 4: grant drops after two words
        mode = 0;
        clr();
        for (int i = 0; i < 4; i++) wr(8'h40 + 8'(i));
        drop_at    = 2;
        drop_armed = 1;
        mode = 1;
        cyc(25);
        chk("t4_n", qd.size(), 4);
        if (qd.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("t4_d%0d", i), qd[i], 8'h40 + 8'(i));
                chk($sformatf("t4_l%0d", i), ql[i], 32'(i == 3));
            end
        end
        chk("t4_ngap", gaps.size(), 1);
        if (gaps.size() == 1) chk("t4_gap", gaps[0], 1);

        // 5: starvation flag
        mode = 0;
        clr();
        wr(8'h55);
        k = 0;
        while (req !== 1'b1 && k < 10) begin
            cyc(1);
            k++;
        end
        chk("t5_req", req, 1);
        cyc(62);
        chk("t5_st62", starve_err, 0);
        cyc(1);
        chk("t5_st63", starve_err, 1);
        cyc(7);
        chk("t5_reqhold", req, 1);
        mode = 1;
        cyc(10);
        chk("t5_n", qd.size(), 1);
        if (qd.size() == 1) begin
            chk("t5_d", qd[0], 8'h55);
            chk("t5_l", ql[0], 1);
        end
        chk("t5_sticky", starve_err, 1);

        // 6: reset in the middle of a burst
        mode = 0;
        clr();
        for (int i = 0; i < 4; i++) wr(8'h60 + 8'(i));
        mode = 1;
        k = 0;
        while (nwords < 1 && k < 20) begin
            cyc(1);
            k++;
        end
        chk("t6_started", 32'(nwords >= 1), 1);
        n_rst = 1'b0;
        cyc(1);
        n_rst = 1'b1;
        chk("t6_req", req, 0);
        chk("t6_bv", bus_valid, 0);
        chk("t6_cnt", fifo_count, 0);
        chk("t6_starve", starve_err, 0);
        chk("t6_busy", busy, 0);
        k = nwords;
        mode = 2;
        cyc(5);
        chk("t6_nobus", nwords, k);
        chk("t6_req2", req, 0);
        chk("t6_busy2", busy, 0);
        mode = 0;
        cyc(2);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
